// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline.
//   NOP_INSTR     : canonical bubble instruction (addi x0, x0, 0)
//   fetch_state_t : fetch-stage request FSM states
//     REQ  - idle, may issue a request for PCF
//     WAIT - one request outstanding, waiting for ImemValid
//     HOLD - a fetched word is parked because decode could not take it
//     DROP - an outstanding response belongs to a squashed path; discard it
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/flopenrc.sv
// Resettable, enabled, synchronously clearable register.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, loads CLR_VAL
//   en    : load d when high
//   clr   : synchronous clear to CLR_VAL, wins over en
//   d     : next value
//   q     : registered value
module flopenrc #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] CLR_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next value: clear beats enable, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = CLR_VAL;
        end else if (en) begin
            q_d = d;
        end else begin
            q_d = q_q;
        end
    end

    // Storage element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= CLR_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, issues at most one outstanding request
// to a variable-latency instruction memory and fills the IF/ID register.
//   clk, reset            : clock; asynchronous active-low reset
//   StallF, StallD, FlushD: hazard unit controls
//   PCSrcE, PCTargetE     : redirect from Execute
//   ImemReq, ImemAddr     : request strobe/address (always accepted)
//   ImemValid, ImemRdata  : response strobe/word
//   InstrD, PCD, PCPlus4D, ValidD : IF/ID register contents
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemValid,
    input  logic [31:0]     ImemRdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam int              IFID_W  = 32 + XLEN + XLEN + 1;
    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};
    localparam logic [IFID_W-1:0] IFID_BUBBLE =
        {NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}}, 1'b0};

    fetch_state_t      state_q, state_d;
    logic [XLEN-1:0]   pcf_q, pcf_d;
    logic [31:0]       hold_instr_q, hold_instr_d;
    logic              hold_valid_q, hold_valid_d;

    logic [XLEN-1:0]   pc_plus4_s;
    logic [XLEN-1:0]   pc_held_s;
    logic              accept_s;
    logic              hold_release_s;
    logic              imem_req_s;
    logic [XLEN-1:0]   imem_addr_s;
    logic [IFID_W-1:0] ifid_d_s;
    logic [IFID_W-1:0] ifid_q_s;

    // PCF is bumped when a word is captured, so a parked word sits at PCF-4.
    assign pc_plus4_s     = pcf_q + PC_STEP;
    assign pc_held_s      = pcf_q - PC_STEP;
    assign accept_s       = ImemValid && !StallD && !FlushD && !PCSrcE;
    assign hold_release_s = hold_valid_q && !StallD && !FlushD && !PCSrcE;

    // State, PC and hold-buffer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= REQ;
            pcf_q        <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            hold_instr_q <= hold_instr_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // Next-state, next-PC and hold-buffer logic; a redirect overrides all.
    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        hold_instr_d = hold_instr_q;
        hold_valid_d = hold_valid_q;
        case (state_q)
            REQ: begin
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    state_d = REQ;
                end else if (!StallF) begin
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    // A response still in flight belongs to the old path.
                    state_d = ImemValid ? REQ : DROP;
                end else if (ImemValid) begin
                    pcf_d = pc_plus4_s;
                    if (accept_s) begin
                        // Chained request keeps us in WAIT unless fetch is stalled.
                        state_d = StallF ? REQ : WAIT;
                    end else begin
                        hold_instr_d = ImemRdata;
                        hold_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pcf_d        = PCTargetE;
                    hold_valid_d = 1'b0;
                    state_d      = REQ;
                end else if (hold_release_s) begin
                    hold_valid_d = 1'b0;
                    state_d      = REQ;
                end else begin
                    state_d = HOLD;
                end
            end
            DROP: begin
                if (PCSrcE) begin
                    pcf_d = PCTargetE;
                end else begin
                    pcf_d = pcf_q;
                end
                // Once the stale response has arrived nothing is outstanding.
                state_d = ImemValid ? REQ : DROP;
            end
            default: begin
                state_d      = REQ;
                pcf_d        = RESET_PC;
                hold_valid_d = 1'b0;
            end
        endcase
    end

    // Request strobe/address and IF/ID load value.
    always_comb begin
        imem_req_s  = 1'b0;
        imem_addr_s = pcf_q;
        ifid_d_s    = IFID_BUBBLE;
        case (state_q)
            REQ: begin
                imem_req_s  = !StallF && !PCSrcE;
                imem_addr_s = pcf_q;
            end
            WAIT: begin
                if (accept_s) begin
                    ifid_d_s    = {ImemRdata, pcf_q, pc_plus4_s, 1'b1};
                    imem_req_s  = !StallF;
                    imem_addr_s = pc_plus4_s;
                end else begin
                    imem_req_s = 1'b0;
                end
            end
            HOLD: begin
                if (hold_release_s) begin
                    ifid_d_s = {hold_instr_q, pc_held_s, pcf_q, 1'b1};
                end else begin
                    ifid_d_s = IFID_BUBBLE;
                end
            end
            DROP: begin
                imem_req_s = 1'b0;
            end
            default: begin
                imem_req_s = 1'b0;
            end
        endcase
    end

    // No request may escape while reset is held.
    assign ImemReq  = imem_req_s && reset;
    assign ImemAddr = imem_addr_s;

    flopenrc #(
        .WIDTH   (IFID_W),
        .CLR_VAL (IFID_BUBBLE)
    ) u_ifid (
        .clk   (clk),
        .rst_n (reset),
        .en    (!StallD),
        .clr   (FlushD),
        .d     (ifid_d_s),
        .q     (ifid_q_s)
    );

    assign {InstrD, PCD, PCPlus4D, ValidD} = ifid_q_s;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemValid;
    logic [31:0] ImemRdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int chk  = 0;
    int pass = 0;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .ImemReq   (ImemReq),
        .ImemAddr  (ImemAddr),
        .ImemValid (ImemValid),
        .ImemRdata (ImemRdata),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input logic v, input logic [31:0] a);
        ImemValid = v;
        ImemRdata = v ? w(a) : 32'h0000_0000;
    endtask

    task automatic do_reset();
        reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = 32'h0000_0000;
        ImemValid = 1'b0; ImemRdata = 32'h0000_0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = 32'h0000_0000; resp(1'b0, 32'h0);
        tick();
        chk++; if (ImemReq !== 1'b0) $display("FAIL reset_req got %b want 0", ImemReq); else pass++;
        chk++; if (InstrD !== NOP || ValidD !== 1'b0 || PCD !== 32'h0 || PCPlus4D !== 32'h0)
            $display("FAIL reset_ifid got %h/%b/%h/%h want %h/0/0/0", InstrD, ValidD, PCD, PCPlus4D, NOP);
        else pass++;
        reset = 1'b1; StallF = 1'b1;
        #1;
        chk++; if (ImemReq !== 1'b0) $display("FAIL stallf_req got %b want 0", ImemReq); else pass++;
        tick();
        StallF = 1'b0;
        #1;
        chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) $display("FAIL first_req got %b/%h want 1/0", ImemReq, ImemAddr); else pass++;
    endtask

    task automatic test_single_cycle();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            resp(i > 0, 32'(4 * (i - 1)));
            #1;
            chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'(4 * i))
                $display("FAIL stream_req i=%0d got %b/%h want 1/%h", i, ImemReq, ImemAddr, 32'(4 * i));
            else pass++;
            tick();
            if (i > 0) begin
                chk++; if (ValidD !== 1'b1 || PCD !== 32'(4 * (i - 1)) || PCPlus4D !== 32'(4 * i) || InstrD !== w(32'(4 * (i - 1))))
                    $display("FAIL stream_ifid i=%0d got %b/%h/%h/%h", i, ValidD, PCD, PCPlus4D, InstrD);
                else pass++;
            end
        end
    endtask

    task automatic test_latency3();
        do_reset();
        resp(1'b0, 32'h0); #1;
        chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) $display("FAIL lat_req0 got %b/%h want 1/0", ImemReq, ImemAddr); else pass++;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk++; if (ImemReq !== 1'b0) $display("FAIL lat_wait_req i=%0d got %b want 0", i, ImemReq); else pass++;
            tick();
            chk++; if (ValidD !== 1'b0) $display("FAIL lat_wait_valid i=%0d got %b want 0", i, ValidD); else pass++;
        end
        resp(1'b1, 32'h0); #1;
        chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h4) $display("FAIL lat_chain got %b/%h want 1/4", ImemReq, ImemAddr); else pass++;
        tick();
        chk++; if (InstrD !== w(32'h0) || ValidD !== 1'b1 || PCD !== 32'h0) $display("FAIL lat_ifid got %h/%b/%h", InstrD, ValidD, PCD); else pass++;
        resp(1'b0, 32'h0);
        tick();
        chk++; if (ValidD !== 1'b0 || InstrD !== NOP) $display("FAIL lat_bubble got %b/%h want 0/%h", ValidD, InstrD, NOP); else pass++;
    endtask

    task automatic test_stall_hold();
        do_reset();
        resp(1'b0, 32'h0); tick();
        resp(1'b1, 32'h0); tick();
        resp(1'b1, 32'h4); tick();
        resp(1'b1, 32'h8); StallD = 1'b1; #1;
        chk++; if (ImemReq !== 1'b0) $display("FAIL hold_noreq got %b want 0", ImemReq); else pass++;
        tick();
        chk++; if (InstrD !== w(32'h4) || PCD !== 32'h4) $display("FAIL hold_keep1 got %h/%h want %h/4", InstrD, PCD, w(32'h4)); else pass++;
        resp(1'b0, 32'h0); #1;
        chk++; if (ImemReq !== 1'b0) $display("FAIL hold_noreq2 got %b want 0", ImemReq); else pass++;
        tick();
        chk++; if (InstrD !== w(32'h4) || ValidD !== 1'b1) $display("FAIL hold_keep2 got %h/%b", InstrD, ValidD); else pass++;
        StallD = 1'b0; #1;
        chk++; if (ImemReq !== 1'b0) $display("FAIL hold_release_req got %b want 0", ImemReq); else pass++;
        tick();
        chk++; if (InstrD !== w(32'h8) || PCD !== 32'h8 || PCPlus4D !== 32'hC || ValidD !== 1'b1)
            $display("FAIL hold_deliver got %h/%h/%h/%b", InstrD, PCD, PCPlus4D, ValidD);
        else pass++;
        #1;
        chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'hC) $display("FAIL hold_next_req got %b/%h want 1/c", ImemReq, ImemAddr); else pass++;
        tick();
        chk++; if (ValidD !== 1'b0) $display("FAIL hold_no_dup got %b want 0", ValidD); else pass++;
    endtask

    task automatic test_redirect_drop();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            resp(i > 0, 32'(4 * (i - 1)));
            tick();
        end
        resp(1'b0, 32'h0); PCSrcE = 1'b1; PCTargetE = 32'h40; #1;
        chk++; if (ImemReq !== 1'b0) $display("FAIL redir_noreq got %b want 0", ImemReq); else pass++;
        tick();
        chk++; if (ValidD !== 1'b0) $display("FAIL redir_bubble got %b want 0", ValidD); else pass++;
        PCSrcE = 1'b0; resp(1'b1, 32'h10); #1;
        chk++; if (ImemReq !== 1'b0) $display("FAIL drop_noreq got %b want 0", ImemReq); else pass++;
        tick();
        chk++; if (ValidD !== 1'b0 || InstrD !== NOP) $display("FAIL drop_discard got %b/%h want 0/%h", ValidD, InstrD, NOP); else pass++;
        resp(1'b0, 32'h0); #1;
        chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h40) $display("FAIL drop_target_req got %b/%h want 1/40", ImemReq, ImemAddr); else pass++;
        tick();
        resp(1'b1, 32'h40);
        tick();
        chk++; if (InstrD !== w(32'h40) || PCD !== 32'h40 || ValidD !== 1'b1) $display("FAIL drop_target_ifid got %h/%h/%b", InstrD, PCD, ValidD); else pass++;
    endtask

    task automatic test_redirect_flush_same();
        do_reset();
        resp(1'b0, 32'h0); tick();
        resp(1'b1, 32'h0); PCSrcE = 1'b1; PCTargetE = 32'h80; FlushD = 1'b1; #1;
        chk++; if (ImemReq !== 1'b0) $display("FAIL flush_noreq got %b want 0", ImemReq); else pass++;
        tick();
        chk++; if (InstrD !== NOP || ValidD !== 1'b0 || PCD !== 32'h0) $display("FAIL flush_ifid got %h/%b/%h", InstrD, ValidD, PCD); else pass++;
        resp(1'b0, 32'h0); PCSrcE = 1'b0; FlushD = 1'b0; #1;
        chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h80) $display("FAIL flush_target_req got %b/%h want 1/80", ImemReq, ImemAddr); else pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; resp(1'b0, 32'h0);
        tick();
        PCSrcE = 1'b0; #1;
        chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'hFFFF_FFFC) $display("FAIL wrap_req got %b/%h want 1/fffffffc", ImemReq, ImemAddr); else pass++;
        tick();
        resp(1'b1, 32'hFFFF_FFFC); #1;
        chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) $display("FAIL wrap_chain got %b/%h want 1/0", ImemReq, ImemAddr); else pass++;
        tick();
        chk++; if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || ValidD !== 1'b1) $display("FAIL wrap_ifid got %h/%h/%b", PCD, PCPlus4D, ValidD); else pass++;
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        resp(1'b0, 32'h0); tick();
        resp(1'b1, 32'h0); tick();
        resp(1'b0, 32'h0); reset = 1'b0; #1;
        chk++; if (ImemReq !== 1'b0 || ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0)
            $display("FAIL rst_wait_outputs got %b/%b/%h/%h/%h", ImemReq, ValidD, InstrD, PCD, PCPlus4D);
        else pass++;
        resp(1'b1, 32'h4);
        tick();
        resp(1'b0, 32'h0); reset = 1'b1; #1;
        chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) $display("FAIL rst_wait_restart got %b/%h want 1/0", ImemReq, ImemAddr); else pass++;
        tick();
        chk++; if (ValidD !== 1'b0) $display("FAIL rst_wait_stale got %b want 0", ValidD); else pass++;
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_latency3();
        test_stall_hold();
        test_redirect_drop();
        test_redirect_flush_same();
        test_wrap();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
